apb_master_bridge: RTL



---
 rtl/apb_master_bridge_if.sv | 55 +++++
 rtl/apb_master_bridge.sv | 114 +++++++++++
 2 files changed

// File: rtl/apb_master_bridge_if.sv
// ---------------------------------------------------------------------------
// apb_master_bridge_if
//
// Bundles the command/response handshake and the APB bus seen by
// apb_master_bridge.
//   master modport : the bridge's view (takes commands, drives APB).
//   slave modport  : the environment's view (issues commands, models the
//                    APB slave).
//
// Signals:
//   req_valid/req_ready/req_write/req_addr/req_wdata : command handshake
//   rsp_valid/rsp_rdata/rsp_error/rsp_timeout        : one-cycle response
//   paddr/pwrite/pwdata/pselx/penable                : APB request side
//   prdata/pready/pslave_error                       : APB completion side
// ---------------------------------------------------------------------------
interface apb_master_bridge_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_error;
    logic                  rsp_timeout;

    logic [ADDR_WIDTH-1:0] paddr;
    logic                  pwrite;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pselx;
    logic                  penable;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslave_error;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  prdata, pready, pslave_error,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
        output paddr, pwrite, pwdata, pselx, penable
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output prdata, pready, pslave_error,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
        input  paddr, pwrite, pwdata, pselx, penable
    );
endinterface

// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge
//
// Single-outstanding APB master. Converts a valid/ready command into one APB
// SETUP/ACCESS transfer and returns the result on a one-cycle response
// strobe. A wait-state counter aborts transfers whose slave holds pready low
// for TIMEOUT_CYCLES ACCESS cycles.
//
// Ports:
//   pclk   : clock, all logic on the rising edge
//   preset : synchronous active-high reset
//   bus    : apb_master_bridge_if.master
//            command  req_valid/req_ready/req_write/req_addr/req_wdata
//            response rsp_valid/rsp_rdata/rsp_error/rsp_timeout
//            APB      paddr/pwrite/pwdata/pselx/penable/prdata/pready/
//                     pslave_error
//
// All outputs are registered except req_ready.
// ---------------------------------------------------------------------------
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                pclk,
    input  logic                preset,
    apb_master_bridge_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Counter value on the last ACCESS cycle allowed before abort; with the
    // counter starting at 0 this yields exactly TIMEOUT_CYCLES ACCESS cycles.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    logic [7:0] wait_cnt;

    // Combinational so a new command can be taken in the same cycle the
    // previous response is presented.
    assign bus.req_ready = (state == IDLE) && !preset;

    always_ff @(posedge pclk) begin
        if (preset) begin
            state           <= IDLE;
            wait_cnt        <= 8'd0;
            bus.pselx       <= 1'b0;
            bus.penable     <= 1'b0;
            bus.paddr       <= '0;
            bus.pwrite      <= 1'b0;
            bus.pwdata      <= '0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_rdata   <= '0;
            bus.rsp_error   <= 1'b0;
            bus.rsp_timeout <= 1'b0;
        end else begin
            // Response is a single-cycle strobe.
            bus.rsp_valid <= 1'b0;

            case (state)
                IDLE: begin
                    // req_ready is implied here (IDLE and not in reset).
                    if (bus.req_valid) begin
                        bus.paddr  <= bus.req_addr;
                        bus.pwrite <= bus.req_write;
                        bus.pwdata <= bus.req_wdata;
                        bus.pselx  <= 1'b1;
                        wait_cnt   <= 8'd0;
                        state      <= SETUP;
                    end
                end

                SETUP: begin
                    bus.penable <= 1'b1;
                    state       <= ACCESS;
                end

                ACCESS: begin
                    // pready wins over the timeout on the final wait cycle.
                    if (bus.pready) begin
                        bus.pselx       <= 1'b0;
                        bus.penable     <= 1'b0;
                        bus.rsp_valid   <= 1'b1;
                        bus.rsp_rdata   <= bus.pwrite ? '0 : bus.prdata;
                        bus.rsp_error   <= bus.pslave_error;
                        bus.rsp_timeout <= 1'b0;
                        state           <= IDLE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        bus.pselx       <= 1'b0;
                        bus.penable     <= 1'b0;
                        bus.rsp_valid   <= 1'b1;
                        bus.rsp_rdata   <= '0;
                        bus.rsp_error   <= 1'b1;
                        bus.rsp_timeout <= 1'b1;
                        state           <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                default: begin
                    bus.pselx   <= 1'b0;
                    bus.penable <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
